mem_access_ctrl: RTL and testbench

Initiator side of the data-memory interface. Accepts load/store ops from the EX/MEM pipeline register and drives a request/ready handshake to a (possibly multi-cycle) word-wide data memory. Generates byte-lane enables, aligns and extends load data, and stalls the pipeline until each access completes or times out.

---
 rtl/mem_access_ctrl_if.sv | 20 ++
 rtl/mem_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Word-wide data-memory bus: the initiator raises mem_req, and the memory completes the access with mem_ready.
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: turns EX/MEM load/store ops into request/ready accesses with lane enables and load alignment.
// Optional MEM_ACCESS_UNALIGNED_TRAP_EN: trap misaligned half/word accesses instead of forcing them aligned.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_valid,
    input  logic                     op_load,
    input  logic                     op_store,
    input  logic [1:0]               op_size,
    input  logic                     op_signed,
    input  logic [31:0]              op_addr,
    input  logic [31:0]              op_wdata,
    output logic                     stall,
    output logic                     ld_valid,
    output logic [31:0]              ld_data,
    output logic                     exc_misalign,
    output logic                     timeout_err,
    mem_access_ctrl_if.master        mem
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req_q, we_q;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       be_q;
    logic             load_q, signed_q;
    logic [1:0]       size_q, off_q;
    logic             ld_valid_q, timeout_q, misalign_q;
    logic [31:0]      ld_data_q;

    logic             accept;
    logic             misalign_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      ld_ext;

    assign accept = op_valid && (op_load || op_store);

`ifdef MEM_ACCESS_UNALIGNED_TRAP_EN
    assign misalign_c = ((op_size == 2'b01) && op_addr[0]) ||
                        (op_size[1] && (op_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = op_wdata;
        case (op_size)
            2'b00: begin
                be_c    = 4'b0001 << op_addr[1:0];
                wdata_c = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = op_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction uses the fields latched at accept, so the pipeline may change op_* during BUSY.
    always_comb begin
        byte_sel = mem.mem_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = {{16{signed_q & half_sel[15]}}, half_sel};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            load_q     <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            ld_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
            ld_data_q  <= '0;
        end else begin
            ld_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_q   <= !op_store;
                        we_q     <= op_store;
                        size_q   <= op_size;
                        signed_q <= op_signed;
                        off_q    <= op_addr[1:0];
                        addr_q   <= {op_addr[31:2], 2'b00};
                        be_q     <= be_c;
                        wdata_q  <= wdata_c;
                        cnt      <= '0;
                        if (misalign_c) begin
                            misalign_q <= 1'b1;
                            state      <= DONE;
                        end else begin
                            req_q <= 1'b1;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mem.mem_ready) begin
                        req_q <= 1'b0;
                        state <= DONE;
                        if (load_q) begin
                            ld_valid_q <= 1'b1;
                            ld_data_q  <= ld_ext;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        req_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        ld_data_q <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall         = ((state == IDLE) && accept) || (state == BUSY);
    assign ld_valid      = ld_valid_q;
    assign ld_data       = ld_data_q;
    assign timeout_err   = timeout_q;
    assign exc_misalign  = misalign_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, reset-in-BUSY sequence, and random ops checked against a byte-level model.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_UNALIGNED_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int TMO = 16;

    typedef struct packed {
        logic [7:0]  stall;
        logic [7:0]  busy;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lv;
        logic [31:0] ld;
        logic        to;
        logic        mis;
    } exp_t;

    typedef struct packed {
        logic        v, ld, st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr, wd, rd;
        logic [7:0]  lat;
        exp_t        e;
    } vec_t;

    typedef struct {
        int          stall_cycles;
        int          busy;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr, wdata;
        logic        lv;
        logic [31:0] ld;
        logic        to, mis;
        logic        unstable, early, late;
    } obs_t;

    logic        clk, rst_n;
    logic        op_valid, op_load, op_store, op_signed;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        stall, ld_valid, exc_misalign, timeout_err;
    logic [31:0] ld_data;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
        .op_size(op_size), .op_signed(op_signed), .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
        .exc_misalign(exc_misalign), .timeout_err(timeout_err),
        .mem(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int st, input int bz, input logic we, input logic [3:0] be,
                                input logic [31:0] a, input logic [31:0] w, input logic lv,
                                input logic [31:0] ld, input logic to, input logic mis);
        exp_t e;
        e.stall = 8'(st); e.busy = 8'(bz); e.we = we; e.be = be; e.addr = a; e.wdata = w;
        e.lv = lv; e.ld = ld; e.to = to; e.mis = mis;
        return e;
    endfunction

    // Reference model: derives the access from byte counts and offsets, independent of any state machine.
    function automatic exp_t model(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                                   input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rd, input int lat, input logic [31:0] prev);
        exp_t e;
        int n, off;
        logic [63:0] val, mask;
        logic [31:0] w;
        e = '0;
        e.ld = prev;
        if (!(v && (ld || st))) return e;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (TRAP && (int'(addr[1:0]) % n) != 0) begin
            e.stall = 8'd1;
            e.mis   = 1'b1;
            return e;
        end
        off = (int'(addr[1:0]) / n) * n;
        e.addr = addr & ~32'h3;
        e.we   = st;
        e.be   = 4'(((1 << n) - 1) << off);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        e.wdata = w;
        if (lat >= TMO) begin
            e.stall = 8'(TMO + 1);
            e.busy  = 8'(TMO);
            e.to    = 1'b1;
            e.ld    = '0;
            return e;
        end
        e.busy  = 8'(lat + 1);
        e.stall = 8'(lat + 2);
        if (!st) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            val  = ({32'd0, rd} >> (8 * off)) & mask;
            if (sg && n < 4 && val[8*n-1]) val = val | ~mask;
            e.lv = 1'b1;
            e.ld = val[31:0];
        end
        return e;
    endfunction

    // Presents one op and plays the memory: mem_ready comes on BUSY cycle lat+1, junk outside BUSY.
    task automatic run_op(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                          input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] rd, input int lat, output obs_t o);
        o.stall_cycles = 0; o.busy = 0; o.we = 0; o.be = 0; o.addr = 0; o.wdata = 0;
        o.lv = 0; o.ld = 0; o.to = 0; o.mis = 0; o.unstable = 0; o.early = 0; o.late = 0;
        @(posedge clk); #1;
        op_valid = v; op_load = ld; op_store = st; op_size = sz; op_signed = sg;
        op_addr = ad; op_wdata = wd; bus.mem_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (o.busy == 0) begin
                    o.we = bus.mem_we; o.be = bus.mem_be; o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
                end else if (bus.mem_we !== o.we || bus.mem_be !== o.be ||
                             bus.mem_addr !== o.addr || bus.mem_wdata !== o.wdata) begin
                    o.unstable = 1'b1;
                end
                bus.mem_ready = (o.busy == lat);
                bus.mem_rdata = (o.busy == lat) ? rd : $urandom;
                o.busy++;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end
            if (stall) begin
                o.stall_cycles++;
                if (ld_valid || timeout_err || exc_misalign) o.early = 1'b1;
            end else begin
                o.lv = ld_valid; o.ld = ld_data; o.to = timeout_err; o.mis = exc_misalign;
                break;
            end
        end
        @(posedge clk); #1;
        op_valid = 0; op_load = 0; op_store = 0; bus.mem_ready = 1'b0;
        @(negedge clk);
        o.late = stall || bus.mem_req || ld_valid || timeout_err || exc_misalign;
    endtask

    task automatic compare(input string tag, input obs_t o, input exp_t e);
        check({tag, ".stall"},    32'(o.stall_cycles), 32'(e.stall));
        check({tag, ".busy"},     32'(o.busy),         32'(e.busy));
        check({tag, ".ld_valid"}, 32'(o.lv),           32'(e.lv));
        check({tag, ".ld_data"},  o.ld,                e.ld);
        check({tag, ".timeout"},  32'(o.to),           32'(e.to));
        check({tag, ".misalign"}, 32'(o.mis),          32'(e.mis));
        check({tag, ".quiet"},    {29'd0, o.unstable, o.early, o.late}, 32'd0);
        if (e.busy != 0) begin
            check({tag, ".we"},    32'(o.we),   32'(e.we));
            check({tag, ".be"},    32'(o.be),   32'(e.be));
            check({tag, ".addr"},  o.addr,      e.addr);
            check({tag, ".wdata"}, o.wdata,     e.wdata);
        end
    endtask

    vec_t        tbl [14];
    obs_t        o;
    exp_t        e;
    logic [31:0] exp_ld;
    int          busy, lat, r;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; op_valid = 0; op_load = 0; op_store = 0; op_size = 0; op_signed = 0;
        op_addr = 0; op_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;

        //        v  ld st sz     sg addr        wdata       rdata       lat    stall        busy         we be       addr       wdata              lv ld_data                      to mis
        tbl[0]  = '{1, 1, 0, 2'd2, 0, 32'h4,     32'h0,      32'h0000000a, 8'd0,  mk(2,          1,           0, 4'hF, 32'h4,   32'h0,             1, 32'h0000000a,               0, 0)};
        tbl[1]  = '{1, 0, 1, 2'd0, 0, 32'h7,     32'hA5,     32'h0,        8'd0,  mk(2,          1,           1, 4'h8, 32'h4,   32'hA5A5A5A5,      0, 32'h0000000a,               0, 0)};
        tbl[2]  = '{1, 1, 0, 2'd1, 1, 32'h2,     32'h0,      32'h8001FFFF, 8'd0,  mk(2,          1,           0, 4'hC, 32'h0,   32'h0,             1, 32'hFFFF8001,               0, 0)};
        tbl[3]  = '{1, 1, 0, 2'd1, 0, 32'h2,     32'h0,      32'h8001FFFF, 8'd0,  mk(2,          1,           0, 4'hC, 32'h0,   32'h0,             1, 32'h00008001,               0, 0)};
        tbl[4]  = '{1, 1, 0, 2'd0, 1, 32'h1,     32'h0,      32'h00007F80, 8'd0,  mk(2,          1,           0, 4'h2, 32'h0,   32'h0,             1, 32'h0000007F,               0, 0)};
        tbl[5]  = '{1, 1, 0, 2'd2, 0, 32'h100,   32'h0,      32'h12345678, 8'd5,  mk(7,          6,           0, 4'hF, 32'h100, 32'h0,             1, 32'h12345678,               0, 0)};
        tbl[6]  = '{1, 1, 0, 2'd2, 0, 32'h20,    32'h0,      32'h0,        8'd99, mk(17,         16,          0, 4'hF, 32'h20,  32'h0,             0, 32'h0,                      1, 0)};
        tbl[7]  = '{1, 1, 0, 2'd2, 0, 32'h6,     32'h0,      32'hCAFEF00D, 8'd0,  mk(TRAP?1:2,   TRAP?0:1,    0, 4'hF, 32'h4,   32'h0,             !TRAP, TRAP?32'h0:32'hCAFEF00D, 0, TRAP)};
        tbl[8]  = '{1, 0, 0, 2'd2, 0, 32'h4,     32'h0,      32'h0,        8'd0,  mk(0,          0,           0, 4'h0, 32'h0,   32'h0,             0, TRAP?32'h0:32'hCAFEF00D,    0, 0)};
        tbl[9]  = '{1, 1, 1, 2'd2, 0, 32'h10,    32'h11223344, 32'h0,      8'd1,  mk(3,          2,           1, 4'hF, 32'h10,  32'h11223344,      0, TRAP?32'h0:32'hCAFEF00D,    0, 0)};
        tbl[10] = '{1, 0, 1, 2'd1, 0, 32'h3,     32'hBEEF,   32'h0,        8'd0,  mk(TRAP?1:2,   TRAP?0:1,    1, 4'hC, 32'h0,   32'hBEEFBEEF,      0, TRAP?32'h0:32'hCAFEF00D,    0, TRAP)};
        tbl[11] = '{1, 1, 0, 2'd3, 1, 32'h8,     32'h0,      32'h80000001, 8'd0,  mk(2,          1,           0, 4'hF, 32'h8,   32'h0,             1, 32'h80000001,               0, 0)};
        tbl[12] = '{1, 1, 0, 2'd0, 1, 32'h3,     32'h0,      32'h80000000, 8'd0,  mk(2,          1,           0, 4'h8, 32'h0,   32'h0,             1, 32'hFFFFFF80,               0, 0)};
        tbl[13] = '{1, 1, 0, 2'd2, 0, 32'h30,    32'h0,      32'h5A5A0001, 8'd15, mk(17,         16,          0, 4'hF, 32'h30,  32'h0,             1, 32'h5A5A0001,               0, 0)};

        #12;
        check("reset.stall",   32'(stall),       32'd0);
        check("reset.req_we",  {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
        check("reset.addr",    bus.mem_addr,     32'd0);
        check("reset.be",      32'(bus.mem_be),  32'd0);
        check("reset.wdata",   bus.mem_wdata,    32'd0);
        check("reset.pulses",  {29'd0, ld_valid, timeout_err, exc_misalign}, 32'd0);
        check("reset.ld_data", ld_data,          32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].v, tbl[i].ld, tbl[i].st, tbl[i].sz, tbl[i].sg, tbl[i].addr,
                   tbl[i].wd, tbl[i].rd, int'(tbl[i].lat), o);
            compare($sformatf("vec%0d", i), o, tbl[i].e);
        end

        // Reset asserted mid-cycle during the 3rd BUSY cycle of a load that never completes.
        @(posedge clk); #1;
        op_valid = 1; op_load = 1; op_store = 0; op_size = 2'd2; op_signed = 0;
        op_addr = 32'h40; bus.mem_ready = 1'b0;
        busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.mem_req) busy++;
            if (busy == 3) break;
        end
        check("rst_seq.busy_reached", 32'(busy), 32'd3);
        rst_n = 1'b0; op_valid = 0; op_load = 0;
        #1;
        check("rst_seq.req_drop", 32'(bus.mem_req), 32'd0);
        check("rst_seq.stall",    32'(stall),       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_seq.idle%0d", c),
                  {27'd0, stall, bus.mem_req, ld_valid, timeout_err, exc_misalign}, 32'd0);
        end
        check("rst_seq.ld_data", ld_data, 32'd0);
        exp_ld = 32'd0;
        run_op(1, 1, 0, 2'd1, 1, 32'h42, 32'h0, 32'hF00D1234, 2, o);
        e = model(1, 1, 0, 2'd1, 1, 32'h42, 32'h0, 32'hF00D1234, 2, exp_ld);
        compare("rst_seq.next_op", o, e);
        exp_ld = e.ld;

        for (int i = 0; i < 300; i++) begin
            logic        v, ld, st, sg;
            logic [1:0]  sz;
            logic [31:0] ad, wd, rd;
            v  = ($urandom_range(0, 9) != 0);
            ld = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            ad = $urandom; wd = $urandom; rd = $urandom;
            r = int'($urandom_range(0, 19));
            if (r < 12)      lat = r % 4;
            else if (r < 16) lat = int'($urandom_range(4, 15));
            else if (r < 18) lat = 15;
            else             lat = 40;
            e = model(v, ld, st, sz, sg, ad, wd, rd, lat, exp_ld);
            run_op(v, ld, st, sz, sg, ad, wd, rd, lat, o);
            compare($sformatf("rnd%0d", i), o, e);
            exp_ld = e.ld;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
